mem_dump_reader: RTL and testbench

Hardware memory-dump engine for the single-cycle MIPS CPU: on a start pulse, reads a contiguous word range from a synchronous-read memory port (data memory or register-file debug port) and streams it out as bytes over a valid/ready interface. It is the hardware counterpart of the bench's memory preload: the preload writes state into the CPU, and this block reads CPU state back out. Sits beside `MipsCPU`, sharing the memory's debug read port while the CPU is halted.

---
 rtl/mem_dump_pkg.sv | 23 ++
 rtl/word_byte_serializer.sv | 65 ++++++
 rtl/mem_dump_reader.sv | 108 ++++++++++
 tb/tb_mem_dump_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory-dump engine.
// MEM_DUMP_ADDR_HDR_EN adds a one-byte address header in front of every word.
package mem_dump_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StSend,
        StDone
    } dump_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

`ifdef MEM_DUMP_ADDR_HDR_EN
    localparam int unsigned HDR_BYTES = 1;
`else
    localparam int unsigned HDR_BYTES = 0;
`endif

    localparam int unsigned BYTES_TOTAL = BYTES_PER_WORD + HDR_BYTES;

endpackage

// File: rtl/word_byte_serializer.sv
// Loads one 32-bit word (plus optional header byte) and shifts it out MSB-first, one byte per
// valid/ready handshake. Honours MEM_DUMP_ADDR_HDR_EN for the header byte.
module word_byte_serializer
    import mem_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        load,
    input  logic [31:0] word,
`ifdef MEM_DUMP_ADDR_HDR_EN
    input  logic [7:0]  hdr,
`endif
    input  logic        last_word,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        word_done
);

    localparam int unsigned ShW = 8 * BYTES_TOTAL;

    logic [ShW-1:0] shreg_q, shreg_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           last_word_q, last_word_d;
    logic           hs;

    // cnt_q holds the number of bytes still to send; zero means nothing is presented.
    assign out_valid = (cnt_q != 3'd0);
    assign hs        = out_valid && out_ready;
    assign out_data  = out_valid ? shreg_q[ShW-1 -: 8] : 8'h00;
    assign out_last  = out_valid && last_word_q && (cnt_q == 3'd1);
    assign word_done = hs && (cnt_q == 3'd1);

    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        last_word_d = last_word_q;
        if (load) begin
`ifdef MEM_DUMP_ADDR_HDR_EN
            shreg_d = {hdr, word};
`else
            shreg_d = word;
`endif
            cnt_d       = 3'(BYTES_TOTAL);
            last_word_d = last_word;
        end else if (hs) begin
            shreg_d = shreg_q << 8;
            cnt_d   = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            shreg_q     <= '0;
            cnt_q       <= 3'd0;
            last_word_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            last_word_q <= last_word_d;
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a contiguous, possibly wrapping, word range from a synchronous-read memory as bytes.
// MEM_DUMP_ADDR_HDR_EN prefixes each word with its address as a header byte.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("mem_dump_reader: DATA_W must be 32");
    end

`ifdef MEM_DUMP_ADDR_HDR_EN
    if (ADDR_W > 8) begin : g_bad_addr_w
        $error("mem_dump_reader: ADDR_W must be <= 8 with the address header enabled");
    end
`endif

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              ser_load;
    logic              word_done;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        end_d    = end_q;
        ser_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    cur_d   = base_addr;
                    end_d   = last_addr;
                    state_d = StRead;
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                ser_load = 1'b1;
                state_d  = StSend;
            end
            StSend: begin
                if (word_done) begin
                    if (cur_q == end_q) begin
                        state_d = StDone;
                    end else begin
                        // Natural ADDR_W overflow gives the wrap through the top of memory.
                        cur_d   = cur_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign mem_rd_en = (state_q == StRead);
    assign mem_addr  = (state_q == StRead) ? cur_q : '0;
    assign busy      = (state_q == StRead) || (state_q == StWait) || (state_q == StSend);
    assign done      = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= StIdle;
            cur_q   <= '0;
            end_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
        end
    end

    word_byte_serializer u_ser (
        .clk       (clk),
        .rst_      (rst_),
        .load      (ser_load),
        .word      (mem_rdata),
`ifdef MEM_DUMP_ADDR_HDR_EN
        .hdr       (8'(cur_q)),
`endif
        .last_word (cur_q == end_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: directed and randomized dumps against a byte-stream
// model built from the word range; honours MEM_DUMP_ADDR_HDR_EN.
module tb_mem_dump_reader;

    localparam int AW = 7;
`ifdef MEM_DUMP_ADDR_HDR_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic          clk;
    logic          rst_;
    logic          start_i;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] last_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [128];
    logic [7:0]  exp_data [$];
    logic        exp_last [$];
    logic [6:0]  exp_addr [$];

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .start_i   (start_i),
        .base_addr (base_addr),
        .last_addr (last_addr),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Expected stream: every word in the (wrapping) range, optional header, then big-endian bytes.
    task automatic build_model(input logic [6:0] b, input logic [6:0] l);
        int n;
        logic [6:0] a;
        exp_data.delete();
        exp_last.delete();
        exp_addr.delete();
        n = ((int'(l) - int'(b) + 128) % 128) + 1;
        for (int i = 0; i < n; i++) begin
            a = 7'((int'(b) + i) % 128);
            exp_addr.push_back(a);
`ifdef MEM_DUMP_ADDR_HDR_EN
            exp_data.push_back({1'b0, a});
            exp_last.push_back(1'b0);
`endif
            for (int k = 3; k >= 0; k--) begin
                exp_data.push_back(mem[a][8*k +: 8]);
                exp_last.push_back((i == n - 1) && (k == 0));
            end
        end
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic run_dump(input logic [6:0] b, input logic [6:0] l, input int mode,
                            input int abort_at, input bit poke_start);
        int cyc, reads, seen, nwords, nbytes, bound;
        bit fin, prev_stall, prev_last;
        logic [7:0] prev_data;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        build_model(b, l);
        nwords = exp_addr.size();
        nbytes = exp_data.size();
        bound = nwords * (NB + 2) * 8 + 20;
        reads = 0; seen = 0; fin = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        base_addr = b;
        last_addr = l;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (!fin && cyc < bound) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start_i = poke_start && (cyc == 4);
            if (start_i) begin
                base_addr = b + 7'd40;
                last_addr = b + 7'd41;
            end
            if (abort_at >= 0 && seen == abort_at && out_valid) begin
                rst_ = 1'b1;
                @(negedge clk);
                chk_idle_outputs("abort");
                rst_ = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_no_read", 32'(mem_rd_en), 0);
                    chk("abort_no_byte", 32'(out_valid), 0);
                end
                return;
            end
            chk("busy", 32'(busy), 32'(!done));
            if (mem_rd_en) begin
                reads++;
                if (exp_addr.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
                chk("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && out_ready) begin
                seen++;
                if (exp_data.size() == 0) chk("extra_byte", 1, 0);
                else begin
                    chk("byte", 32'(out_data), 32'(exp_data.pop_front()));
                    chk("last", 32'(out_last), 32'(exp_last.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                chk("done_bytes", seen, nbytes);
                chk("done_reads", reads, nwords);
                if (mode == 0) chk("done_cycle", cyc, 1 + nwords * (NB + 2));
                fin = 1;
                start_i = poke_start;
            end
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        chk("no_timeout", 32'(fin), 1);
        chk("done_pulse", 32'(done), 0);
        repeat (3) begin
            chk("idle_after_rd", 32'(mem_rd_en), 0);
            chk("idle_after_busy", 32'(busy), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] rb;
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        rst_ = 1'b1;
        start_i = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        last_addr = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_ = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        mem[5] = 32'h1234ABCD;
        run_dump(7'd5, 7'd5, 0, -1, 0);

        mem[0] = 32'h00000001;
        mem[1] = 32'h00000002;
        mem[2] = 32'h00000003;
        run_dump(7'd0, 7'd2, 0, -1, 0);

        run_dump(7'd126, 7'd1, 0, -1, 0);
        run_dump(7'd10, 7'd17, 1, -1, 0);

        run_dump(7'd20, 7'd25, 0, 2 * NB + 1, 0);
        run_dump(7'd60, 7'd62, 0, -1, 0);

        run_dump(7'h10, 7'h12, 2, -1, 1);

        repeat (4) begin
            rb = 7'($urandom_range(0, 127));
            run_dump(rb, rb + 7'($urandom_range(0, 5)), int'($urandom_range(0, 2)), -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
